// File: rtl/exu_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - default operand width
//   - funct3 encodings of the RISC-V M-extension operations
//   - FSM state type
package exu_mdu_pkg;

  localparam int unsigned MDU_XLEN_DEFAULT = 32;

  localparam logic [2:0] ysyx_23060251_mdu_mul    = 3'd0;
  localparam logic [2:0] ysyx_23060251_mdu_mulh   = 3'd1;
  localparam logic [2:0] ysyx_23060251_mdu_mulhsu = 3'd2;
  localparam logic [2:0] ysyx_23060251_mdu_mulhu  = 3'd3;
  localparam logic [2:0] ysyx_23060251_mdu_div    = 3'd4;
  localparam logic [2:0] ysyx_23060251_mdu_divu   = 3'd5;
  localparam logic [2:0] ysyx_23060251_mdu_rem    = 3'd6;
  localparam logic [2:0] ysyx_23060251_mdu_remu   = 3'd7;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_DONE
  } mdu_state_e;

endpackage

// File: rtl/exu_mdu_core.sv
// One iteration step of the magnitude datapath, purely combinational.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : 2*XLEN accumulator
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd_i   : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o    : accumulator after one step
module exu_mdu_core
  import exu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN_DEFAULT
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] part;
  logic [XLEN:0] diff;

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole accumulator right (carry enters the top).
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: shift left one bit, then try to subtract the divisor. The
    // partial remainder is always below the divisor, so a borrow shows up
    // exactly as diff[XLEN].
    part = acc_i[2*XLEN-1:XLEN-1];
    diff = part - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {part[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/exu_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit (E stage).
// Accepts one operation per E-side handshake, iterates XLEN cycles on
// operand magnitudes, applies the sign fix-up once and holds the result
// until the M-pipe takes it.
//   clock, reset          : clock, synchronous active-high reset
//   E_valid_i / e_ready_o : operation handshake from E-pipe
//   op_i, src1_i, src2_i  : funct3 and operands, sampled only on accept
//   kill_i                : flush; drops any in-flight or held operation
//   e_valid_o / M_ready_i : result handshake to M-pipe
//   res_o                 : registered result
//   busy_o                : unit is not idle
module exu_mdu
  import exu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            E_valid_i,
  output logic            e_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            kill_i,
  output logic            e_valid_o,
  input  logic            M_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              neg_q, neg_d;    // product / quotient negate
  logic              rneg_q, rneg_d;  // remainder negate (dividend sign)
  logic              valid_q, valid_d;

  logic              sgn1, sgn2, neg1, neg2, div0, ovf;
  logic [XLEN-1:0]   mag1, mag2, quo, rem;
  logic [2*XLEN-1:0] step, prod;

  exu_mdu_core #(
    .XLEN (XLEN)
  ) u_core (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step)
  );

  always_comb begin
    // Operand decode, only meaningful in the accept cycle.
    sgn1 = (op_i == ysyx_23060251_mdu_mul)    || (op_i == ysyx_23060251_mdu_mulh) ||
           (op_i == ysyx_23060251_mdu_mulhsu) || (op_i == ysyx_23060251_mdu_div)  ||
           (op_i == ysyx_23060251_mdu_rem);
    sgn2 = (op_i == ysyx_23060251_mdu_mul) || (op_i == ysyx_23060251_mdu_mulh) ||
           (op_i == ysyx_23060251_mdu_div) || (op_i == ysyx_23060251_mdu_rem);
    neg1 = sgn1 && src1_i[XLEN-1];
    neg2 = sgn2 && src2_i[XLEN-1];
    mag1 = neg1 ? -src1_i : src1_i;
    mag2 = neg2 ? -src2_i : src2_i;
    div0 = (src2_i == '0);
    ovf  = ((op_i == ysyx_23060251_mdu_div) || (op_i == ysyx_23060251_mdu_rem)) &&
           (src1_i == XMIN) && (src2_i == '1);

    // Sign fix-up on the final step's accumulator.
    prod = neg_q ? -step : step;
    quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem  = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    valid_d = valid_q;

    unique case (state_q)
      MDU_IDLE: begin
        if (E_valid_i) begin
          op_d   = op_i;
          neg_d  = neg1 ^ neg2;
          rneg_d = neg1;
          if (op_i[2] && (div0 || ovf)) begin
            // op_i[1] selects REM/REMU over DIV/DIVU.
            state_d = MDU_DONE;
            valid_d = 1'b1;
            cnt_d   = '0;
            if (div0) res_d = op_i[1] ? src1_i : '1;
            else      res_d = op_i[1] ? '0 : src1_i;
          end else begin
            state_d = MDU_CALC;
            cnt_d   = CNT_W'(XLEN);
            acc_d   = {{XLEN{1'b0}}, (op_i[2] ? mag1 : mag2)};
            opnd_d  = op_i[2] ? mag2 : mag1;
          end
        end
      end
      MDU_CALC: begin
        acc_d = step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_DONE;
          valid_d = 1'b1;
          if (!op_q[2])
            res_d = (op_q == ysyx_23060251_mdu_mul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          else
            res_d = op_q[1] ? rem : quo;
        end
      end
      MDU_DONE: begin
        if (M_ready_i) begin
          state_d = MDU_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (kill_i) begin
      state_d = MDU_IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      valid_q <= valid_d;
    end
  end

  assign e_ready_o = (state_q == MDU_IDLE);
  assign busy_o    = (state_q != MDU_IDLE);
  assign e_valid_o = valid_q;
  assign res_o     = res_q;

endmodule

// File: tb/tb_exu_mdu.sv
// Self-checking bench for exu_mdu at XLEN = 32: directed corner cases,
// backpressure, kill and mid-operation reset, then randomized operations
// checked against a plain-arithmetic reference model.
module tb_exu_mdu;

  logic        clock = 1'b0;
  logic        reset;
  logic        E_valid_i;
  logic        e_ready_o;
  logic [2:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        kill_i;
  logic        e_valid_o;
  logic        M_ready_i;
  logic [31:0] res_o;
  logic        busy_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  exu_mdu #(
    .XLEN (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .E_valid_i (E_valid_i),
    .e_ready_o (e_ready_o),
    .op_i      (op_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .kill_i    (kill_i),
    .e_valid_o (e_valid_o),
    .M_ready_i (M_ready_i),
    .res_o     (res_o),
    .busy_o    (busy_o)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: M-extension semantics with 64-bit arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op, check latency/result, optionally hold M_ready_i low for
  // `hold` extra DONE cycles, then complete the result handshake.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned hold, input string tag);
    logic [31:0] exp;
    int unsigned n, lat_exp;
    bit          hold_ok;
    exp     = ref_mdu(op, a, b);
    lat_exp = is_special(op, a, b) ? 1 : 33;
    n = 0;
    while (!e_ready_o && n < 100) begin tick(); n++; end
    check_eq({tag, " ready_in"}, 64'(e_ready_o), 64'd1);
    E_valid_i = 1'b1; op_i = op; src1_i = a; src2_i = b; M_ready_i = 1'b0;
    tick();
    E_valid_i = 1'b0; op_i = 3'($urandom); src1_i = $urandom; src2_i = $urandom;
    check_eq({tag, " busy"}, 64'(busy_o), 64'd1);
    n = 1;
    while (!e_valid_o && n < 100) begin tick(); n++; end
    check_eq({tag, " valid"}, 64'(e_valid_o), 64'd1);
    check_eq({tag, " latency"}, 64'(n), 64'(lat_exp));
    check_eq({tag, " res"}, 64'(res_o), 64'(exp));
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
        tick();
        if (res_o !== exp || e_valid_o !== 1'b1 || e_ready_o !== 1'b0) hold_ok = 1'b0;
      end
      check_eq({tag, " hold"}, 64'(hold_ok), 64'd1);
    end
    M_ready_i = 1'b1;
    tick();
    M_ready_i = 1'b0;
    check_eq({tag, " ready_after"}, 64'(e_ready_o), 64'd1);
    check_eq({tag, " valid_after"}, 64'(e_valid_o), 64'd0);
  endtask

  initial begin
    reset = 1'b1; E_valid_i = 1'b0; op_i = '0; src1_i = '0; src2_i = '0;
    kill_i = 1'b0; M_ready_i = 1'b0;
    tick();
    check_eq("rst valid", 64'(e_valid_o), 64'd0);
    check_eq("rst res", 64'(res_o), 64'd0);
    check_eq("rst busy", 64'(busy_o), 64'd0);
    check_eq("rst ready", 64'(e_ready_o), 64'd1);
    tick();
    reset = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7_m3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 0, "mulhu_min");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, "mulhsu");
    run_op(3'd4, 32'd7, 32'd0, 0, "div_by0");
    run_op(3'd6, 32'd7, 32'd0, 0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 0, "divu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5, "div_bp");
    run_op(3'd7, 32'd0, 32'd0, 5, "remu_by0_bp");

    // Kill has priority over accept.
    E_valid_i = 1'b1; kill_i = 1'b1; op_i = 3'd0; src1_i = 32'd3; src2_i = 32'd5;
    tick();
    E_valid_i = 1'b0; kill_i = 1'b0;
    check_eq("kill_vs_accept busy", 64'(busy_o), 64'd0);
    check_eq("kill_vs_accept ready", 64'(e_ready_o), 64'd1);

    // Kill 10 cycles into CALC, then immediately start new ops.
    E_valid_i = 1'b1; op_i = 3'd0; src1_i = $urandom; src2_i = $urandom;
    tick();
    E_valid_i = 1'b0;
    repeat (10) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check_eq("kill ready", 64'(e_ready_o), 64'd1);
    check_eq("kill valid", 64'(e_valid_o), 64'd0);
    run_op(3'd3, 32'd3, 32'd5, 0, "post_kill mulhu");
    run_op(3'd0, 32'd3, 32'd5, 0, "post_kill mul");

    // Reset mid-CALC.
    E_valid_i = 1'b1; op_i = 3'd5; src1_i = $urandom; src2_i = 32'd3;
    tick();
    E_valid_i = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst valid", 64'(e_valid_o), 64'd0);
    check_eq("midrst res", 64'(res_o), 64'd0);
    check_eq("midrst busy", 64'(busy_o), 64'd0);
    check_eq("midrst ready", 64'(e_ready_o), 64'd1);
    run_op(3'd3, 32'd3, 32'd5, 0, "post_rst mulhu");
    run_op(3'd0, 32'd3, 32'd5, 0, "post_rst mul");

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick_val();
      rb  = pick_val();
      run_op(rop, ra, rb, $urandom_range(0, 2), $sformatf("rnd%0d op%0d", i, rop));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exu_mdu.md
# exu_mdu

Iterative RISC-V M-extension multiply/divide unit in the E stage, parametrised in XLEN. It accepts one operation per handshake, computes it over multiple cycles with a shift-add multiplier and a restoring divider, and holds the result until the M-pipe consumes it. The exu selects between its single-cycle ALU result and this unit's result. Stall and flush ride on the same valid/ready handshake used between E and M.

## Interface

Parameters:
- XLEN, 32: operand and result width, any even value ≥ 8.
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived, not overridden).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- E_valid_i  in  1  operation valid from E-pipe.
- e_ready_o  out  1  unit can accept (combinational, state == IDLE).
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1_i  in  XLEN  rs1 (multiplicand / dividend).
- src2_i  in  XLEN  rs2 (multiplier / divisor).
- kill_i  in  1  flush; discards any in-flight or held operation.
- e_valid_o  out  1  result valid to M-pipe.
- M_ready_i  in  1  M-pipe accepts result.
- res_o  out  XLEN  result, registered.
- busy_o  out  1  state != IDLE.

## Operation

- States: IDLE, CALC, DONE.
- IDLE: e_ready_o = 1. On E_valid_i & ~kill_i, latch op and operand magnitudes plus sign flags.
  - Normal ops go to CALC with counter = XLEN.
  - Special divide cases go straight to DONE.
- Signedness:
  - MUL and MULH treat both operands as signed.
  - MULHSU treats src1 as signed and src2 as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
  - DIV and REM treat both operands as signed.
- Datapath works on magnitudes; sign fix-up (two's-complement negate) is applied once, on entry to DONE.
- Multiply: 2·XLEN accumulator. Each CALC cycle adds the shifted multiplicand when the current multiplier LSB is set, then shifts.
  - Product negated iff the effective operand signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per CALC cycle.
  - Quotient negated iff the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved in IDLE with no CALC:
  - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give src1.
  - Signed overflow (src1 = 1<<(XLEN-1), src2 = all-ones, DIV/REM): DIV gives src1; REM gives 0.
- CALC: decrement counter each cycle. When the counter reaches 1, apply sign fix-up, write res_o and go to DONE.
- DONE: e_valid_o = 1 and res_o stable. Return to IDLE on M_ready_i.
- kill_i, any state: next state IDLE, e_valid_o = 0, and the operation is lost. kill_i has priority over accept and over DONE → IDLE completion.
- reset has priority over kill_i.

## Timing

- Reset values: state IDLE, e_valid_o 0, res_o 0, busy_o 0, counter 0. Because e_ready_o is combinational from state, it reads 1 in the cycle after reset.
- Accept in cycle T. Normal op: CALC spans T+1 … T+XLEN, and e_valid_o = 1 from T+XLEN+1.
- Special-case divide: e_valid_o = 1 from T+1.
- No back-to-back accept: after the result handshake in cycle D, e_ready_o = 1 in D+1. Throughput is therefore one op per XLEN+2 cycles.
- Backpressure: with M_ready_i low, the unit holds DONE indefinitely and keeps e_ready_o low.
- Kill in cycle K: e_ready_o = 1 in K+1. A new op accepted in K+1 must be unaffected by the killed op's state.
- Operand inputs are sampled only in the accept cycle and may change freely afterwards.

## Structure

- Shared package (core defines):
  - op encodings ysyx_23060251_mdu_{mul,mulh,mulhsu,mulhu,div,divu,rem,remu};
  - the state enum;
  - the XLEN default.
- One natural sub-module, exu_mdu_core: the combinational one-step shift/add and shift/subtract slice. It is instantiated once and selected by an is_div flag.
- FSM, counter, sign handling and handshake live in exu_mdu.
- The exu instantiates exu_mdu and muxes res_o by opinfo.

## Test plan

- MUL 7 × 0xFFFFFFFD (-3), XLEN=32, M_ready_i=1 → res_o 0xFFFFFFEB; e_valid_o rises exactly 33 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU on the same operands → 0x40000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 7 / 0 → 0xFFFFFFFF and REM 7 / 0 → 7, each valid 1 cycle after accept. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- REM 0xFFFFFFF9 (-7) % 2 → 0xFFFFFFFF (-1). DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Backpressure: M_ready_i low for 5 cycles in DONE → res_o, e_valid_o and e_ready_o=0 all hold. The handshake completes on the 6th cycle, and e_ready_o=1 the cycle after.
- kill_i pulsed 10 cycles into CALC → e_valid_o never rises for that op; e_ready_o=1 next cycle. A following MULHU 3 × 5 → 0; a following MUL 3 × 5 → 15. Reset asserted mid-CALC gives the same recovery, with all outputs at reset values.
